// File: rtl/ps2_cmd_sched_pkg.sv
// PS/2 protocol constants, scheduler state encoding and the frame/parity helper
// shared by the command scheduler and its environment.
package ps2_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR  = 8'hFC;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  localparam logic [7:0] PS2_CMD_RESET            = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE_REPORTING = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_LEDS         = 8'hED;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_TXDONE,
    ST_WAIT_ACK,
    ST_DONE
  } ps2_state_e;

  typedef enum logic {
    PH_CMD,
    PH_ARG
  } ps2_phase_e;

  // Transceiver word: odd parity bit above the data byte.
  function automatic logic [8:0] ps2_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_cmd_sched_if.sv
// Requester, transceiver and receive-stream signals of the PS/2 command scheduler.
// master = environment side (requesters + transceiver), slave = scheduler.
interface ps2_cmd_sched_if;

  logic       req0;
  logic [7:0] cmd0;
  logic [7:0] arg0;
  logic       has_arg0;
  logic       done0;
  logic       err0;

  logic       req1;
  logic [7:0] cmd1;
  logic [7:0] arg1;
  logic       has_arg1;
  logic       done1;
  logic       err1;

  logic       tx_ena;
  logic [8:0] tx_cmd;
  logic       tx_busy;
  logic [7:0] rx_code;
  logic       rx_new;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport master (
    output req0, cmd0, arg0, has_arg0,
    output req1, cmd1, arg1, has_arg1,
    output tx_busy, rx_code, rx_new,
    input  done0, err0, done1, err1,
    input  tx_ena, tx_cmd, rx_data, rx_valid, busy
  );

  modport slave (
    input  req0, cmd0, arg0, has_arg0,
    input  req1, cmd1, arg1, has_arg1,
    input  tx_busy, rx_code, rx_new,
    output done0, err0, done1, err1,
    output tx_ena, tx_cmd, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/ps2_cmd_sched_timeout.sv
// Saturating phase timer: clear restarts it, expired_o holds once LIMIT cycles
// have elapsed since the clear, and the count never wraps.
module ps2_timeout #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned TERM = (LIMIT > 0) ? LIMIT - 1 : 0;
  localparam int unsigned W    = (TERM > 1) ? $clog2(TERM + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is LIMIT-1 so the owning FSM leaves its wait state on
  // exactly the LIMIT-th edge after the clear.
  assign expired_o = (cnt_q == W'(TERM));

endmodule

// File: rtl/ps2_cmd_sched.sv
// PS/2 command scheduler: arbitrates two requesters, sends command (+ optional
// argument) through the transceiver, handles ACK/RESEND/ERROR and forwards other bytes.
module ps2_cmd_sched
  import ps2_pkg::*;
#(
  parameter int unsigned clk_freq   = 56_750_320,
  parameter int unsigned timeout_ms = 20,
  parameter int unsigned max_retry  = 3
) (
  input  logic          clock,
  input  logic          reset,
  ps2_cmd_sched_if.slave bus
);

  localparam int unsigned TMO_LIMIT = clk_freq / 1000 * timeout_ms;
  localparam int unsigned RW        = (max_retry > 1) ? $clog2(max_retry + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(max_retry);

  ps2_state_e    state_q, state_d;
  ps2_phase_e    phase_q, phase_d;
  logic          port_q, port_d;
  logic [8:0]    frame_q, frame_d;
  logic [7:0]    arg_q, arg_d;
  logic          has_arg_q, has_arg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;

  logic       rx_new_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       strobe;
  logic       consumed;
  logic       fwd;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;

  assign strobe = bus.rx_new & ~rx_new_q;
  assign fwd    = strobe & ~consumed;

  ps2_timeout #(
    .LIMIT(TMO_LIMIT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    port_d    = port_q;
    frame_d   = frame_q;
    arg_d     = arg_q;
    has_arg_d = has_arg_q;
    retry_d   = retry_q;
    err_d     = err_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    consumed  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (bus.req0) begin
          port_d    = 1'b0;
          frame_d   = ps2_frame(bus.cmd0);
          arg_d     = bus.arg0;
          has_arg_d = bus.has_arg0;
        end else if (bus.req1) begin
          port_d    = 1'b1;
          frame_d   = ps2_frame(bus.cmd1);
          arg_d     = bus.arg1;
          has_arg_d = bus.has_arg1;
        end
        if (bus.req0 || bus.req1) begin
          phase_d = PH_CMD;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        tmr_en = 1'b1;
        if (bus.tx_busy) begin
          tmr_clr = 1'b1;
          state_d = ST_WAIT_TXDONE;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_WAIT_TXDONE: begin
        tmr_en = 1'b1;
        if (!bus.tx_busy) begin
          tmr_clr = 1'b1;
          state_d = ST_WAIT_ACK;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        // A strobe takes precedence over a coincident timeout; a non-protocol
        // byte leaves the saturated timer to fire on the following cycle.
        if (strobe) begin
          unique case (bus.rx_code)
            PS2_ACK: begin
              consumed = 1'b1;
              if (phase_q == PH_CMD && has_arg_q) begin
                frame_d = ps2_frame(arg_q);
                phase_d = PH_ARG;
                retry_d = '0;
                state_d = ST_LOAD;
              end else begin
                err_d   = 1'b0;
                state_d = ST_DONE;
              end
            end
            PS2_RESEND: begin
              consumed = 1'b1;
              if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_LOAD;
              end else begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end
            end
            PS2_ERROR: begin
              consumed = 1'b1;
              err_d    = 1'b1;
              state_d  = ST_DONE;
            end
            default: begin
              consumed = 1'b0;
            end
          endcase
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_CMD;
      port_q    <= 1'b0;
      frame_q   <= '0;
      arg_q     <= '0;
      has_arg_q <= 1'b0;
      retry_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      port_q    <= port_d;
      frame_q   <= frame_d;
      arg_q     <= arg_d;
      has_arg_q <= has_arg_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_new_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_new_q   <= bus.rx_new;
      rx_valid_q <= fwd;
      if (fwd) begin
        rx_data_q <= bus.rx_code;
      end
    end
  end

  assign bus.tx_ena   = (state_q == ST_LOAD) ||
                        ((state_q == ST_WAIT_BUSY) && !bus.tx_busy && !tmr_exp);
  assign bus.tx_cmd   = frame_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done0    = (state_q == ST_DONE) && !port_q;
  assign bus.err0     = (state_q == ST_DONE) && !port_q && err_q;
  assign bus.done1    = (state_q == ST_DONE) && port_q;
  assign bus.err1     = (state_q == ST_DONE) && port_q && err_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_ps2_cmd_sched.sv
// Bench for ps2_cmd_sched: a procedural transceiver/device model answers each
// transmitted frame from a reply script; a behavioural model predicts the outcome.
module tb_ps2_cmd_sched;
  import ps2_pkg::*;

  localparam int unsigned CLK_FREQ   = 50_000;
  localparam int unsigned TIMEOUT_MS = 2;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned LIMIT      = CLK_FREQ / 1000 * TIMEOUT_MS;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ps2_cmd_sched_if bus();

  ps2_cmd_sched #(
    .clk_freq  (CLK_FREQ),
    .timeout_ms(TIMEOUT_MS),
    .max_retry (MAX_RETRY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done0_cnt   = 0;
  int done1_cnt   = 0;
  int last_done_cyc = 0;
  logic last_err  = 1'b0;
  int busy_fall_cyc  = 0;
  int first_rise_cyc = 0;
  bit exp_err;

  logic [7:0] got_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] script[$];
  logic [8:0] exp_frames[$];
  logic [8:0] seen_frames[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.done0) begin
      done0_cnt++;
      last_err = bus.err0;
      last_done_cyc = cyc;
    end
    if (bus.done1) begin
      done1_cnt++;
      last_err = bus.err1;
      last_done_cyc = cyc;
    end
    if (bus.rx_valid) got_rx.push_back(bus.rx_data);
  end

  function automatic logic par_odd(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(b[i]);
    return (n % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_code = b;
    bus.rx_new  = 1'b1;
    tick();
    bus.rx_new  = 1'b0;
    tick();
  endtask

  // Transceiver: accept the frame, show busy for a few cycles, then go idle.
  task automatic serve_tx(output logic [8:0] f);
    int n;
    f = bus.tx_cmd;
    bus.tx_busy = 1'b1;
    tick();
    n = 0;
    while (bus.tx_ena && n < 20) begin
      tick();
      n++;
    end
    check("tx_ena_release", 32'(bus.tx_ena), 0);
    tick();
    tick();
    bus.tx_busy = 1'b0;
    tick();
    busy_fall_cyc = cyc;
  endtask

  // Outcome from the protocol rules: each byte is sent until ACKed; RESEND
  // allows MAX_RETRY extra sends per byte; ERROR or exhausted retries abort.
  task automatic model_txn(input logic [7:0] c, input logic [7:0] a, input bit ha);
    int k, resends;
    bit fin, acked;
    logic [7:0] v, r;
    exp_frames.delete();
    exp_err = 1'b0;
    k = 0;
    fin = 1'b0;
    for (int b = 0; b < (ha ? 2 : 1) && !fin; b++) begin
      v = (b == 0) ? c : a;
      resends = 0;
      acked = 1'b0;
      while (!fin && !acked) begin
        exp_frames.push_back({par_odd(v), v});
        r = script[k];
        k++;
        if (r == PS2_ACK) acked = 1'b1;
        else if (r == PS2_RESEND) begin
          resends++;
          if (resends > int'(MAX_RETRY)) begin
            fin = 1'b1;
            exp_err = 1'b1;
          end
        end else begin
          fin = 1'b1;
          exp_err = 1'b1;
        end
      end
    end
  endtask

  task automatic run_txn(input bit port, input logic [7:0] c, input logic [7:0] a,
                         input bit ha, input bit junk_ok);
    int k, d0, d1, t;
    logic [8:0] f;
    logic [7:0] j;
    while (script.size() < 8) script.push_back(PS2_ACK);
    model_txn(c, a, ha);
    got_rx.delete();
    exp_rx.delete();
    seen_frames.delete();
    d0 = done0_cnt;
    d1 = done1_cnt;
    k = 0;
    first_rise_cyc = -1;
    if (!port) begin
      bus.cmd0 = c; bus.arg0 = a; bus.has_arg0 = ha; bus.req0 = 1'b1;
    end else begin
      bus.cmd1 = c; bus.arg1 = a; bus.has_arg1 = ha; bus.req1 = 1'b1;
    end
    t = 0;
    while ((done0_cnt + done1_cnt) == (d0 + d1) && t < 3000) begin
      if (bus.tx_ena) begin
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
        serve_tx(f);
        seen_frames.push_back(f);
        if (junk_ok && $urandom_range(0, 3) == 0) begin
          j = 8'($urandom_range(0, 32'hF9));
          send_byte(j);
          exp_rx.push_back(j);
        end
        send_byte((k < script.size()) ? script[k] : 8'h00);
        k++;
      end else begin
        tick();
      end
      t++;
    end
    if (!port) bus.req0 = 1'b0;
    else       bus.req1 = 1'b0;
    check("frames_n", 32'(seen_frames.size()), 32'(exp_frames.size()));
    for (int i = 0; i < seen_frames.size() && i < exp_frames.size(); i++)
      check("frame", 32'(seen_frames[i]), 32'(exp_frames[i]));
    check("done0_cnt", 32'(done0_cnt - d0), port ? 0 : 1);
    check("done1_cnt", 32'(done1_cnt - d1), port ? 1 : 0);
    check("err", 32'(last_err), 32'(exp_err));
    check("fwd_n", 32'(got_rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
      check("fwd_byte", 32'(got_rx[i]), 32'(exp_rx[i]));
  endtask

  initial begin
    int n, d_before, p0_done;
    logic [8:0] f;
    logic [7:0] c, a;
    bit ha, p;
    int r;

    bus.req0 = 0; bus.cmd0 = '0; bus.arg0 = '0; bus.has_arg0 = 0;
    bus.req1 = 0; bus.cmd1 = '0; bus.arg1 = '0; bus.has_arg1 = 0;
    bus.tx_busy = 0; bus.rx_code = '0; bus.rx_new = 0;

    tick(); tick(); tick();
    check("rst_busy",     32'(bus.busy), 0);
    check("rst_tx_ena",   32'(bus.tx_ena), 0);
    check("rst_tx_cmd",   32'(bus.tx_cmd), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_rx_data",  32'(bus.rx_data), 0);
    check("rst_done",     32'({bus.done0, bus.err0, bus.done1, bus.err1}), 0);
    reset = 1'b0;
    tick();

    // Reset command, no argument, then BAT result bytes and a stray FA.
    script = '{PS2_ACK};
    run_txn(1'b0, PS2_CMD_RESET, 8'h00, 1'b0, 1'b0);
    check("reset_frame", 32'(seen_frames[0]), 32'h1FF);
    check("reset_err", 32'(last_err), 0);
    send_byte(PS2_BAT_OK);
    send_byte(8'h00);
    send_byte(PS2_ACK);
    tick();
    check("bat_n", 32'(got_rx.size()), 3);
    if (got_rx.size() == 3) begin
      check("bat_aa", 32'(got_rx[0]), 32'hAA);
      check("bat_00", 32'(got_rx[1]), 32'h00);
      check("idle_fa", 32'(got_rx[2]), 32'hFA);
    end

    // Set LEDs on port 1 with argument.
    script = '{PS2_ACK, PS2_ACK};
    run_txn(1'b1, PS2_CMD_SET_LEDS, 8'h02, 1'b1, 1'b0);
    check("leds_n", 32'(seen_frames.size()), 2);
    if (seen_frames.size() == 2) begin
      check("leds_cmd", 32'(seen_frames[0]), 32'h1ED);
      check("leds_arg", 32'(seen_frames[1]), 32'h002);
    end

    // Simultaneous requests: port 0 first, port 1 only after done0.
    bus.cmd1 = 8'h33; bus.arg1 = 8'h00; bus.has_arg1 = 1'b0; bus.req1 = 1'b1;
    script = '{PS2_ACK};
    run_txn(1'b0, PS2_CMD_ENABLE_REPORTING, 8'h00, 1'b0, 1'b0);
    check("prio_frame", 32'(seen_frames[0]), 32'h0F4);
    p0_done = last_done_cyc;
    script = '{PS2_ACK};
    run_txn(1'b1, 8'h33, 8'h00, 1'b0, 1'b0);
    check("p1_after_done0", 32'(first_rise_cyc > p0_done), 1);

    // RESEND four times: four sends, then abort.
    script = '{PS2_RESEND, PS2_RESEND, PS2_RESEND, PS2_RESEND};
    run_txn(1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
    check("resend_n", 32'(seen_frames.size()), 4);
    check("resend_err", 32'(last_err), 1);

    // No ACK: timeout measured from WAIT_ACK entry; 0x12 forwarded mid-wait.
    got_rx.delete();
    d_before = done0_cnt;
    bus.cmd0 = PS2_CMD_ENABLE_REPORTING; bus.has_arg0 = 1'b0; bus.req0 = 1'b1;
    n = 0;
    while (!bus.tx_ena && n < 20) begin tick(); n++; end
    check("tmo_tx_ena", 32'(bus.tx_ena), 1);
    serve_tx(f);
    for (int i = 0; i < 40; i++) tick();
    send_byte(8'h12);
    n = 0;
    while (done0_cnt == d_before && n < 3 * int'(LIMIT)) begin tick(); n++; end
    bus.req0 = 1'b0;
    check("tmo_done", 32'(done0_cnt - d_before), 1);
    check("tmo_err", 32'(last_err), 1);
    check("tmo_cycles", 32'(last_done_cyc - busy_fall_cyc), LIMIT);
    check("tmo_fwd_n", 32'(got_rx.size()), 1);
    if (got_rx.size() == 1) check("tmo_fwd", 32'(got_rx[0]), 32'h12);
    tick();

    // Reset in WAIT_ACK: silent abort, held request re-arbitrated.
    bus.cmd0 = PS2_CMD_RESET; bus.has_arg0 = 1'b0; bus.req0 = 1'b1;
    n = 0;
    while (!bus.tx_ena && n < 20) begin tick(); n++; end
    serve_tx(f);
    tick(); tick(); tick();
    d_before = done0_cnt;
    reset = 1'b1;
    #1;
    check("rst_ack_tx_ena", 32'(bus.tx_ena), 0);
    check("rst_ack_busy", 32'(bus.busy), 0);
    tick(); tick();
    reset = 1'b0;
    check("rst_ack_nodone", 32'(done0_cnt), 32'(d_before));
    n = 0;
    while (!bus.tx_ena && n < 10) begin tick(); n++; end
    check("rearb_tx_ena", 32'(bus.tx_ena), 1);
    check("rearb_frame", 32'(bus.tx_cmd), 32'h1FF);
    serve_tx(f);
    send_byte(PS2_ACK);
    bus.req0 = 1'b0;
    check("rearb_done", 32'(done0_cnt - d_before), 1);
    tick(); tick();

    // Randomised transactions against the model.
    for (int t = 0; t < 12; t++) begin
      p  = 1'($urandom_range(0, 1));
      c  = 8'($urandom);
      a  = 8'($urandom);
      ha = 1'($urandom_range(0, 1));
      script.delete();
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 9));
        script.push_back((r < 6) ? PS2_ACK : (r < 9) ? PS2_RESEND : PS2_ERROR);
      end
      run_txn(p, c, a, ha, 1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
